// File: rtl/prog_loader.sv
// prog_loader: serial (8N1) program loader for the CPU's external write port.
// The host sends a count header N, then N program bytes. The loader writes
// those bytes to memory addresses 0..N-1 and holds the CPU in reset until the
// load is complete.
// Optional feature macro: CHECKSUM_EN. When it is defined, the data is followed
// by one checksum byte equal to (N + sum of data bytes) mod 256.
// Keep ADDR_W <= 7. N is a single byte, so larger depths could never be filled.
module prog_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int ADDR_W       = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   output logic              ewr,
   output logic [ADDR_W-1:0] ead,
   output logic [7:0]        edat,
   output logic              cpu_rstreq,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   // ---------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

   rx_state_t        rx_state_reg, rx_state_next;
   logic             rx_s1_reg, rx_s2_reg, rx_prev_reg;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             start_ok, byte_valid, frame_err;

   // The synchronizer and the previous-sample flop reset low. After reset, a
   // start edge can only be seen once the line has first been observed high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_reg   <= 1'b0;
         rx_s2_reg   <= 1'b0;
         rx_prev_reg <= 1'b0;
      end else begin
         rx_s1_reg   <= rxd;
         rx_s2_reg   <= rx_s1_reg;
         rx_prev_reg <= rx_s2_reg;
      end
   end

   // Receiver state, bit-timing counter and shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_reg <= RX_IDLE;
         cnt_reg      <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
      end else begin
         rx_state_reg <= rx_state_next;
         cnt_reg      <= cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
      end
   end

   // Frame decoding. The start bit is re-checked at mid-bit. The data bits and
   // the stop bit are then sampled once per bit period, at mid-bit.
   always_comb begin
      rx_state_next = rx_state_reg;
      cnt_next      = cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      start_ok      = 1'b0;
      byte_valid    = 1'b0;
      frame_err     = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            if (rx_prev_reg && !rx_s2_reg) begin
               rx_state_next = RX_START;
               cnt_next      = '0;
            end
         end
         RX_START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next = '0;
               if (rx_s2_reg) begin
                  rx_state_next = RX_IDLE;      // glitch: not a real start bit
               end else begin
                  rx_state_next = RX_BITS;
                  bit_idx_next  = '0;
                  start_ok      = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RX_BITS: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               shift_next = {rx_s2_reg, shift_reg[7:1]};
               if (bit_idx_reg == 3'd7) rx_state_next = RX_STOP;
               else                     bit_idx_next  = bit_idx_reg + 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next      = '0;
               rx_state_next = RX_IDLE;
               if (rx_s2_reg) byte_valid = 1'b1;
               else           frame_err  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Load sequencer
   // ---------------------------------------------------------------
   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
`ifdef CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W:0]   n_reg, n_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              ewr_reg, ewr_next;
   logic [ADDR_W-1:0] ead_reg, ead_next;
   logic [7:0]        edat_reg, edat_next;
   logic              busy_reg, busy_next;
   logic              rstreq_reg, rstreq_next;
   logic              last_write;
`ifdef CHECKSUM_EN
   logic [7:0]        sum_reg, sum_next;
`endif

   assign last_write = ({1'b0, addr_reg} == (n_reg - (ADDR_W+1)'(1)));

   // Sequencer state and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_HDR;
         n_reg      <= '0;
         addr_reg   <= '0;
         ewr_reg    <= 1'b0;
         ead_reg    <= '0;
         edat_reg   <= '0;
         busy_reg   <= 1'b0;
         rstreq_reg <= 1'b1;
`ifdef CHECKSUM_EN
         sum_reg    <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         n_reg      <= n_next;
         addr_reg   <= addr_next;
         ewr_reg    <= ewr_next;
         ead_reg    <= ead_next;
         edat_reg   <= edat_next;
         busy_reg   <= busy_next;
         rstreq_reg <= rstreq_next;
`ifdef CHECKSUM_EN
         sum_reg    <= sum_next;
`endif
      end
   end

   // Header check, one write per data byte, then completion or error.
   // The write strobe is a single cycle. Address and data hold afterwards.
   always_comb begin
      state_next  = state_reg;
      n_next      = n_reg;
      addr_next   = addr_reg;
      ewr_next    = 1'b0;
      ead_next    = ead_reg;
      edat_next   = edat_reg;
      busy_next   = busy_reg;
      rstreq_next = (state_reg != S_DONE);   // falls one cycle after DONE is entered
`ifdef CHECKSUM_EN
      sum_next    = sum_reg;
`endif
      case (state_reg)
         S_HDR: begin
            if (start_ok) busy_next = 1'b1;
            if (frame_err) begin
               state_next = S_ERR;
               busy_next  = 1'b0;
            end else if (byte_valid) begin
               if (shift_reg == 8'd0 || {1'b0, shift_reg} > 9'(DEPTH)) begin
                  state_next = S_ERR;
                  busy_next  = 1'b0;
               end else begin
                  n_next     = shift_reg[ADDR_W:0];
                  addr_next  = '0;
                  state_next = S_DATA;
`ifdef CHECKSUM_EN
                  sum_next   = shift_reg;
`endif
               end
            end
         end
         S_DATA: begin
            if (frame_err) begin
               state_next = S_ERR;
               busy_next  = 1'b0;
            end else if (byte_valid) begin
               ewr_next  = 1'b1;
               ead_next  = addr_reg;
               edat_next = shift_reg;
`ifdef CHECKSUM_EN
               sum_next  = sum_reg + shift_reg;
`endif
               if (last_write) begin
`ifdef CHECKSUM_EN
                  state_next = S_CHK;
`else
                  state_next = S_DONE;
                  busy_next  = 1'b0;
`endif
               end else begin
                  addr_next = addr_reg + 1'b1;
               end
            end
         end
`ifdef CHECKSUM_EN
         S_CHK: begin
            if (frame_err) begin
               state_next = S_ERR;
               busy_next  = 1'b0;
            end else if (byte_valid) begin
               state_next = (shift_reg == sum_reg) ? S_DONE : S_ERR;
               busy_next  = 1'b0;
            end
         end
`endif
         S_DONE: ;
         S_ERR:  ;
         default: begin
            state_next = S_ERR;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign ewr        = ewr_reg;
   assign ead        = ead_reg;
   assign edat       = edat_reg;
   assign cpu_rstreq = rstreq_reg;
   assign busy       = busy_reg;
   assign done       = (state_reg == S_DONE);
   assign err        = (state_reg == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader. A scoreboard queue holds the expected (address, data)
// writes, and a negedge monitor pops and compares each write the DUT performs.
// Define CHECKSUM_EN for both the RTL and this bench to run the checksum scenario.
module tb_prog_loader;

   localparam int CPB    = 16;
   localparam int ADDR_W = 5;

   logic              clk, rst, rxd;
   logic              ewr, cpu_rstreq, busy, done, err;
   logic [ADDR_W-1:0] ead;
   logic [7:0]        edat;

   int checks = 0;
   int errors = 0;
   logic [ADDR_W+7:0] exp_q[$];

   prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .ewr(ewr), .ead(ead), .edat(edat),
      .cpu_rstreq(cpu_rstreq), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: checks each write against the scoreboard, checks that ewr is one
   // cycle wide, and checks that cpu_rstreq falls exactly one cycle after done rises.
   logic ewr_prev = 1'b0, done_prev = 1'b0, rq_pending = 1'b0;
   always @(negedge clk) begin
      if (rq_pending && !rst) begin
         checks++;
         if (cpu_rstreq !== 1'b0) begin
            errors++;
            $display("FAIL rstreq_fall: cpu_rstreq=%b required 0 one cycle after done", cpu_rstreq);
         end
      end
      rq_pending = 1'b0;
      if (done === 1'b1 && done_prev === 1'b0 && !rst) begin
         checks++;
         if (cpu_rstreq !== 1'b1) begin
            errors++;
            $display("FAIL rstreq_at_done: cpu_rstreq=%b required 1 in first done cycle", cpu_rstreq);
         end
         rq_pending = 1'b1;
      end
      if (ewr === 1'b1) begin
         $display("write ead=%02h edat=%02h", ead, edat);
         checks++;
         if (ewr_prev === 1'b1) begin
            errors++;
            $display("FAIL ewr_width: ewr high %0d cycles required 1", 2);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got (%02h,%02h) required no write", ead, edat);
         end else begin
            logic [ADDR_W+7:0] e;
            e = exp_q.pop_front();
            if ({ead, edat} !== e) begin
               errors++;
               $display("FAIL write_data: got (%02h,%02h) required (%02h,%02h)",
                        ead, edat, e[ADDR_W+7:8], e[7:0]);
            end
         end
      end
      ewr_prev  = ewr;
      done_prev = done;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(posedge clk);
      end
      rxd = stop;
      repeat (CPB) @(posedge clk);
      rxd = 1'b1;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_data(input logic [7:0] b, input int addr);
      exp_q.push_back({addr[ADDR_W-1:0], b});
      send_byte(b, 1'b1);
   endtask

   task automatic reset_dut();
      rxd = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic check_end(input string name, input logic exp_done, input logic exp_err);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (done !== exp_done || err !== exp_err || busy !== 1'b0 || cpu_rstreq !== exp_err) begin
         errors++;
         $display("FAIL %s_flags: done=%b err=%b busy=%b rstreq=%b required done=%b err=%b busy=0 rstreq=%b",
                  name, done, err, busy, cpu_rstreq, exp_done, exp_err, exp_err);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_writes: %0d outstanding required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset_dut();
      @(negedge clk);
      checks++;
      if ({ewr, ead, edat, cpu_rstreq, busy, done, err} !== {1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: ewr=%b ead=%h edat=%h rq=%b busy=%b done=%b err=%b required 0 0 0 1 0 0 0",
                  ewr, ead, edat, cpu_rstreq, busy, done, err);
      end
   endtask

   task automatic test_basic_load();
      reset_dut();
      send_byte(8'h03, 1'b1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: busy=%b required 1", busy);
      end
      send_data(8'hA1, 0);
      send_data(8'hB2, 1);
      send_data(8'hC3, 2);
      check_end("basic", 1'b1, 1'b0);
      checks++;
      if (ead !== 5'd2 || edat !== 8'hC3) begin
         errors++;
         $display("FAIL basic_hold: ead=%h edat=%h required 02 c3", ead, edat);
      end
      send_byte(8'h44, 1'b1);          // ignored after DONE
      check_end("after_done", 1'b1, 1'b0);
   endtask

   task automatic test_bad_header();
      reset_dut();
      send_byte(8'h00, 1'b1);
      check_end("hdr00", 1'b0, 1'b1);
      reset_dut();
      send_byte(8'h21, 1'b1);
      send_byte(8'h55, 1'b1);          // ignored in ERR
      check_end("hdr21", 1'b0, 1'b1);
   endtask

   task automatic test_full_depth();
      reset_dut();
      send_byte(8'h20, 1'b1);
      for (int i = 0; i < 32; i++) send_data(8'($urandom_range(0, 255)), i);
      check_end("full", 1'b1, 1'b0);
      checks++;
      if (ead !== 5'h1F) begin
         errors++;
         $display("FAIL full_last_addr: ead=%h required 1f", ead);
      end
   endtask

   task automatic test_framing();
      reset_dut();
      send_byte(8'h02, 1'b1);
      send_byte(8'h55, 1'b0);
      check_end("framing", 1'b0, 1'b1);
   endtask

   task automatic test_glitch();
      reset_dut();
      rxd = 1'b0;
      repeat (4) @(posedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL glitch_hdr: busy=%b err=%b done=%b required 0 0 0", busy, err, done);
      end
      send_byte(8'h02, 1'b1);
      rxd = 1'b0;
      repeat (4) @(posedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      send_data(8'h11, 0);
      send_data(8'h22, 1);
      check_end("glitch", 1'b1, 1'b0);
   endtask

   task automatic test_mid_reset();
      reset_dut();
      send_byte(8'h03, 1'b1);
      send_data(8'hAA, 0);
      send_data(8'hBB, 1);
      rxd = 1'b0;                      // partial third byte
      repeat (3 * CPB) @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ewr, ead, edat, cpu_rstreq, busy, done, err} !== {1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_values: ewr=%b ead=%h edat=%h rq=%b busy=%b done=%b err=%b required 0 0 0 1 0 0 0",
                  ewr, ead, edat, cpu_rstreq, busy, done, err);
      end
      repeat (2) @(posedge clk);
      rst = 1'b0;
      rxd = 1'b1;
      repeat (4) @(posedge clk);
      send_byte(8'h01, 1'b1);
      send_data(8'h7E, 0);
      check_end("reload", 1'b1, 1'b0);
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum();
      reset_dut();
      send_byte(8'h02, 1'b1);
      send_data(8'h10, 0);
      send_data(8'h20, 1);
      send_byte(8'h32, 1'b1);
      check_end("chk_good", 1'b1, 1'b0);
      reset_dut();
      send_byte(8'h02, 1'b1);
      send_data(8'h10, 0);
      send_data(8'h20, 1);
      send_byte(8'h33, 1'b1);
      check_end("chk_bad", 1'b0, 1'b1);
   endtask
`endif

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      test_reset();
      test_basic_load();
      test_bad_header();
      test_full_depth();
      test_framing();
      test_glitch();
      test_mid_reset();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
